// File: rtl/avalon_arbiter_if.sv
// Bus bundle for the round-robin register-bus arbiter: the master-side request/response
// signals plus the shared slave command port, with one modport per side.
interface avalon_arbiter_if #(
    parameter int MASTERS      = 2,
    parameter int ADDRESSWIDTH = 4
);
    logic [MASTERS-1:0]              m_read;
    logic [MASTERS-1:0]              m_write;
    logic [MASTERS-1:0]              m_lock;
    logic [MASTERS*ADDRESSWIDTH-1:0] m_address;
    logic [MASTERS*32-1:0]           m_data_in;
    logic [MASTERS-1:0]              m_waitrequest;
    logic [MASTERS-1:0]              m_read_valid;
    logic [31:0]                     m_data_out;
    logic                            s_read;
    logic                            s_write;
    logic [ADDRESSWIDTH-1:0]         s_address;
    logic [31:0]                     s_data_out;
    logic                            s_read_valid;
    logic [31:0]                     s_data_in;
    logic [1:0]                      err;

    // The arbiter sits on the slave side of the masters and drives the peripheral port.
    modport slave (
        input  m_read, m_write, m_lock, m_address, m_data_in, s_read_valid, s_data_in,
        output m_waitrequest, m_read_valid, m_data_out, s_read, s_write, s_address,
               s_data_out, err
    );

    modport master (
        output m_read, m_write, m_lock, m_address, m_data_in, s_read_valid, s_data_in,
        input  m_waitrequest, m_read_valid, m_data_out, s_read, s_write, s_address,
               s_data_out, err
    );
endinterface

// File: rtl/avalon_arbiter.sv
// Round-robin arbiter sharing one register-bus slave port between MASTERS requesters,
// with per-master grant locking, idle-timeout lock release and one-cycle read routing.
module avalon_arbiter #(
    parameter int MASTERS      = 2,
    parameter int ADDRESSWIDTH = 4,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    avalon_arbiter_if.slave  bus
);
    localparam int IDXW = $clog2(MASTERS);
    localparam int CNTW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    lock_state_t         r_state;
    lock_state_t         w_stateNext;
    logic [IDXW-1:0]     r_owner;
    logic [IDXW-1:0]     w_ownerNext;
    logic [CNTW-1:0]     r_idle;
    logic [CNTW-1:0]     w_idleNext;
    logic [IDXW-1:0]     r_lastGrant;
    logic [IDXW-1:0]     r_rdOwner;
    logic                r_rdPending;
    logic [1:0]          r_err;

    logic [MASTERS-1:0]  w_req;
    logic [MASTERS-1:0]  w_grantOneHot;
    logic [MASTERS-1:0]  w_readValid;
    logic [IDXW-1:0]     w_grantIdx;
    logic [IDXW-1:0]     w_cand;
    logic                w_grantValid;
    logic                w_grantRead;
    logic                w_grantWrite;
    logic                w_fwdRead;

    assign w_req = bus.m_read | bus.m_write;

    // Descending scan so the candidate nearest to last_grant+1 is the one left standing.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_cand       = '0;
        if (reset) begin
            if (r_state == LOCKED) begin
                w_grantValid = w_req[r_owner];
                w_grantIdx   = r_owner;
            end else begin
                for (int k = MASTERS; k >= 1; k--) begin
                    w_cand = IDXW'((int'(r_lastGrant) + k) % MASTERS);
                    if (w_req[w_cand]) begin
                        w_grantValid = 1'b1;
                        w_grantIdx   = w_cand;
                    end
                end
            end
        end
    end

    assign w_grantRead  = w_grantValid & bus.m_read[w_grantIdx];
    assign w_grantWrite = w_grantValid & bus.m_write[w_grantIdx];
    assign w_fwdRead    = w_grantRead & ~w_grantWrite;

    always_comb begin
        w_grantOneHot = '0;
        w_readValid   = '0;
        if (w_grantValid) begin
            w_grantOneHot[w_grantIdx] = 1'b1;
        end
        if (bus.s_read_valid && r_rdPending) begin
            w_readValid[r_rdOwner] = 1'b1;
        end
    end

    assign bus.s_write       = w_grantWrite;
    assign bus.s_read        = w_fwdRead;
    assign bus.s_address     = w_grantValid ?
                               bus.m_address[int'(w_grantIdx)*ADDRESSWIDTH +: ADDRESSWIDTH] : '0;
    assign bus.s_data_out    = w_grantValid ? bus.m_data_in[int'(w_grantIdx)*32 +: 32] : '0;
    assign bus.m_waitrequest = w_req & ~w_grantOneHot & {MASTERS{reset}};
    assign bus.m_read_valid  = w_readValid;
    assign bus.m_data_out    = reset ? bus.s_data_in : 32'd0;
    assign bus.err           = r_err;

    // Any owner request is always granted while locked, so a grant doubles as "owner active".
    always_comb begin
        w_stateNext = r_state;
        w_ownerNext = r_owner;
        w_idleNext  = r_idle;
        case (r_state)
            UNLOCKED: begin
                if (w_grantValid && bus.m_lock[w_grantIdx]) begin
                    w_stateNext = LOCKED;
                    w_ownerNext = w_grantIdx;
                    w_idleNext  = '0;
                end
            end
            LOCKED: begin
                if (w_grantValid) begin
                    w_idleNext = '0;
                    if (!bus.m_lock[r_owner]) begin
                        w_stateNext = UNLOCKED;
                    end
                end else if (r_idle == CNTW'(LOCK_TIMEOUT - 1)) begin
                    w_stateNext = UNLOCKED;
                    w_idleNext  = '0;
                end else begin
                    w_idleNext = r_idle + 1'b1;
                end
            end
            default: begin
                w_stateNext = UNLOCKED;
                w_idleNext  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= UNLOCKED;
            r_owner     <= '0;
            r_idle      <= '0;
            r_lastGrant <= IDXW'(MASTERS - 1);
            r_rdPending <= 1'b0;
            r_rdOwner   <= '0;
            r_err       <= 2'b00;
        end else begin
            r_state     <= w_stateNext;
            r_owner     <= w_ownerNext;
            r_idle      <= w_idleNext;
            r_rdPending <= w_fwdRead;
            if (w_grantValid) begin
                r_lastGrant <= w_grantIdx;
            end
            if (w_fwdRead) begin
                r_rdOwner <= w_grantIdx;
            end
            if (bus.s_read_valid && !r_rdPending) begin
                r_err[0] <= 1'b1;
            end
            if (w_grantRead && w_grantWrite) begin
                r_err[1] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_avalon_arbiter.sv
// Self-checking bench for avalon_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural arbiter model.
module tb_avalon_arbiter;
    localparam int M   = 2;
    localparam int AW  = 4;
    localparam int LT  = 16;
    localparam int AWT = M * AW;
    localparam int DWT = M * 32;

    logic clk = 1'b0;
    logic reset;

    avalon_arbiter_if #(.MASTERS(M), .ADDRESSWIDTH(AW)) bus ();

    avalon_arbiter #(.MASTERS(M), .ADDRESSWIDTH(AW), .LOCK_TIMEOUT(LT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Model state: -1 stands for "no owner" / "nothing pending".
    int         mLastGrant;
    int         mOwner;
    int         mIdle;
    int         mPending;
    logic [1:0] mErr;

    function automatic void modelReset();
        mLastGrant = M - 1;
        mOwner     = -1;
        mIdle      = 0;
        mPending   = -1;
        mErr       = 2'b00;
    endfunction

    function automatic int modelGrant();
        if (!reset) return -1;
        if (mOwner >= 0) return (bus.m_read[mOwner] | bus.m_write[mOwner]) ? mOwner : -1;
        for (int k = 1; k <= M; k++) begin
            int c;
            c = (mLastGrant + k) % M;
            if (bus.m_read[c] | bus.m_write[c]) return c;
        end
        return -1;
    endfunction

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // Compare every DUT output against the model, then advance the model past the next edge.
    task automatic checkOutput();
        int              g;
        logic [M-1:0]    expWait;
        logic [M-1:0]    expRv;
        logic [AW-1:0]   expAddr;
        logic [31:0]     expWdata;
        logic [31:0]     expRdata;
        logic [1:0]      expErr;
        logic            expRd;
        logic            expWr;
        g        = modelGrant();
        expWait  = '0;
        expRv    = '0;
        expAddr  = '0;
        expWdata = '0;
        expRd    = 1'b0;
        expWr    = 1'b0;
        expRdata = reset ? bus.s_data_in : 32'd0;
        expErr   = reset ? mErr : 2'b00;
        if (reset) begin
            for (int i = 0; i < M; i++) expWait[i] = (bus.m_read[i] | bus.m_write[i]) && (i != g);
        end
        if (g >= 0) begin
            expWr    = bus.m_write[g];
            expRd    = bus.m_read[g] && !bus.m_write[g];
            expAddr  = bus.m_address[g*AW +: AW];
            expWdata = bus.m_data_in[g*32 +: 32];
        end
        if (reset && bus.s_read_valid && mPending >= 0) expRv[mPending] = 1'b1;

        checkValue("m_waitrequest", bus.m_waitrequest, expWait);
        checkValue("m_read_valid", bus.m_read_valid, expRv);
        checkValue("m_data_out", bus.m_data_out, expRdata);
        checkValue("s_read", bus.s_read, expRd);
        checkValue("s_write", bus.s_write, expWr);
        checkValue("s_address", bus.s_address, expAddr);
        checkValue("s_data_out", bus.s_data_out, expWdata);
        checkValue("err", bus.err, expErr);

        if (!reset) begin
            modelReset();
        end else begin
            if (bus.s_read_valid && mPending < 0) mErr[0] = 1'b1;
            if (g >= 0 && bus.m_read[g] && bus.m_write[g]) mErr[1] = 1'b1;
            mPending = expRd ? g : -1;
            if (mOwner < 0) begin
                if (g >= 0) begin
                    mLastGrant = g;
                    if (bus.m_lock[g]) begin
                        mOwner = g;
                        mIdle  = 0;
                    end
                end
            end else if (g >= 0) begin
                mLastGrant = g;
                mIdle      = 0;
                if (!bus.m_lock[g]) mOwner = -1;
            end else begin
                mIdle++;
                if (mIdle >= LT) begin
                    mOwner = -1;
                    mIdle  = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rstn, input logic [M-1:0] rd, input logic [M-1:0] wr,
                                 input logic [M-1:0] lk, input logic [AWT-1:0] addr,
                                 input logic [DWT-1:0] data, input logic srv,
                                 input logic [31:0] sdin);
        @(negedge clk);
        reset            = rstn;
        bus.m_read       = rd;
        bus.m_write      = wr;
        bus.m_lock       = lk;
        bus.m_address    = addr;
        bus.m_data_in    = data;
        bus.s_read_valid = srv;
        bus.s_data_in    = sdin;
        #2;
        cycle++;
        checkOutput();
    endtask

    initial begin
        logic [M-1:0]   rd;
        logic [M-1:0]   wr;
        logic [M-1:0]   lk;
        logic [AWT-1:0] addr;
        logic [DWT-1:0] data;
        logic           srv;
        logic           rstn;
        logic           quiet;

        reset            = 1'b0;
        bus.m_read       = '0;
        bus.m_write      = '0;
        bus.m_lock       = '0;
        bus.m_address    = '0;
        bus.m_data_in    = '0;
        bus.s_read_valid = 1'b0;
        bus.s_data_in    = '0;
        modelReset();
        $display("[TB] start");

        applyStimulus(1'b0, 2'b11, 2'b11, 2'b00, 8'h21, {32'h1, 32'h2}, 1'b1, 32'h5);
        checkValue("rst_wait", bus.m_waitrequest, 0);
        checkValue("rst_swrite", bus.s_write, 0);
        checkValue("rst_dout", bus.m_data_out, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b00, 2'b11, 2'b00, 8'h21, {32'hB0B0_0001, 32'hA0A0_0000}, 1'b0, 32'd0);
            checkValue("alt_addr", bus.s_address, (i % 2 == 0) ? 1 : 2);
            checkValue("alt_wait", bus.m_waitrequest, (i % 2 == 0) ? 2'b10 : 2'b01);
        end

        applyStimulus(1'b1, 2'b10, 2'b00, 2'b00, 8'h30, '0, 1'b0, 32'd0);
        checkValue("rd_sread", bus.s_read, 1);
        checkValue("rd_saddr", bus.s_address, 3);
        checkValue("rd_rv_early", bus.m_read_valid, 0);
        applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, '0, 1'b1, 32'hDEADBEEF);
        checkValue("rd_valid", bus.m_read_valid, 2'b10);
        checkValue("rd_data", bus.m_data_out, 32'hDEADBEEF);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b00, 2'b11, (i < 3) ? 2'b01 : 2'b00, 8'h65,
                          {32'h1111_0000, 32'h2222_0000}, 1'b0, 32'd0);
            checkValue("lock_wait", bus.m_waitrequest, 2'b10);
            checkValue("lock_addr", bus.s_address, 5);
        end
        applyStimulus(1'b1, 2'b00, 2'b10, 2'b00, 8'h65, '0, 1'b0, 32'd0);
        checkValue("lock_after_wait", bus.m_waitrequest, 0);
        checkValue("lock_after_addr", bus.s_address, 6);

        applyStimulus(1'b1, 2'b00, 2'b11, 2'b01, 8'h65, '0, 1'b0, 32'd0);
        checkValue("to_lock_wait", bus.m_waitrequest, 2'b10);
        for (int i = 0; i < LT; i++) begin
            applyStimulus(1'b1, 2'b00, 2'b10, 2'b00, 8'h65, '0, 1'b0, 32'd0);
            checkValue("to_stall", bus.m_waitrequest, 2'b10);
        end
        applyStimulus(1'b1, 2'b00, 2'b10, 2'b00, 8'h65, '0, 1'b0, 32'd0);
        checkValue("to_release", bus.m_waitrequest, 0);
        checkValue("to_swrite", bus.s_write, 1);

        applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, '0, 1'b1, 32'h1234);
        checkValue("orph_rv", bus.m_read_valid, 0);
        applyStimulus(1'b1, 2'b01, 2'b01, 2'b00, 8'h07, '0, 1'b0, 32'd0);
        checkValue("orph_err", bus.err, 2'b01);
        checkValue("rw_swrite", bus.s_write, 1);
        checkValue("rw_sread", bus.s_read, 0);
        applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, '0, 1'b0, 32'd0);
        checkValue("rw_err", bus.err, 2'b11);

        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 8'h09, '0, 1'b0, 32'd0);
        checkValue("mr_sread", bus.s_read, 1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 8'h21, '0, 1'b1, 32'hCAFE);
            checkValue("mr_wait", bus.m_waitrequest, 0);
            checkValue("mr_rv", bus.m_read_valid, 0);
            checkValue("mr_dout", bus.m_data_out, 0);
            checkValue("mr_sread0", bus.s_read, 0);
            checkValue("mr_err", bus.err, 0);
        end
        applyStimulus(1'b1, 2'b00, 2'b11, 2'b00, 8'h21, '0, 1'b0, 32'd0);
        checkValue("post_rst_wait", bus.m_waitrequest, 2'b10);
        checkValue("post_rst_addr", bus.s_address, 1);
        checkValue("post_rst_err", bus.err, 0);

        // Alternating busy and quiet windows so idle-timeout releases also occur.
        for (int n = 0; n < 3000; n++) begin
            quiet = ((n / 150) % 3 == 2);
            rstn  = ($urandom_range(0, 399) != 0);
            for (int i = 0; i < M; i++) begin
                rd[i] = quiet ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
                wr[i] = quiet ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
                lk[i] = ($urandom_range(0, 3) == 0);
            end
            addr = AWT'($urandom);
            data = {$urandom, $urandom};
            srv  = (mPending >= 0) ? 1'b1 : ($urandom_range(0, 29) == 0);
            applyStimulus(rstn, rd, wr, lk, addr, data, srv, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/avalon_arbiter.md
# avalon_arbiter

Round-robin arbiter that shares the single register-bus slave port of a peripheral's Avalon adapter between `MASTERS` requesters. It forwards one command per cycle, stalls losing requesters with `m_waitrequest`, and routes the slave's fixed one-cycle read response back to the issuing master. A per-master lock holds the grant for atomic sequences, and an idle-timeout breaks an abandoned lock. It sits between the system interconnect masters and the adapter's `read`/`write`/`address`/`data_in`/`read_valid`/`data_out` port.

## Interface
- `MASTERS`, default 2: number of requesters, 2..8.
- `ADDRESSWIDTH`, default 4: slave address width.
- `LOCK_TIMEOUT`, default 16: owner-idle cycles before a held lock is force-released, at least 1.

Ports, one per line: name, direction, width, meaning.
- `clk` input 1: the single clock. All state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset. It is asserted at 0.
- `m_read` input MASTERS: read request, one bit per master.
- `m_write` input MASTERS: write request, one bit per master.
- `m_lock` input MASTERS: request to hold the grant after this transfer.
- `m_address` input MASTERS*ADDRESSWIDTH: master i uses bits `[i*ADDRESSWIDTH +: ADDRESSWIDTH]`.
- `m_data_in` input MASTERS*32: master i uses bits `[i*32 +: 32]`.
- `m_waitrequest` output MASTERS: stall for a requesting master that is not granted.
- `m_read_valid` output MASTERS: one-hot read-data strobe to the issuing master.
- `m_data_out` output 32: read data, broadcast to all masters.
- `s_read` output 1: read command to the slave port.
- `s_write` output 1: write command to the slave port.
- `s_address` output ADDRESSWIDTH: slave address.
- `s_data_out` output 32: slave write data.
- `s_read_valid` input 1: slave read strobe, valid one cycle after `s_read`.
- `s_data_in` input 32: slave read data.
- `err` output 2: sticky error flags. Bit 0 is an orphan `s_read_valid`; bit 1 is simultaneous read and write from one master.

## Operation
- Master i requests when `m_read[i] | m_write[i]`.
- A transfer happens in any cycle where the master requests and its `m_waitrequest[i]` is 0. The master holds its command, address and data stable while stalled.
- Grant is combinational from the current requests and the registered state.
  - If a lock is held, only the lock owner can be granted.
  - Otherwise the first requester found searching from `last_grant+1`, wrapping modulo MASTERS.
- The granted master's command, address and data are muxed onto `s_*`. With no grant, `s_read` and `s_write` are 0 and `s_address`/`s_data_out` are 0.
- `m_waitrequest[i]` = requesting and not granted. It is 0 for idle masters.
- `last_grant` updates to the granted index on every transfer.
- Read tracking:
  - A forwarded read sets `rd_pending` and `rd_owner` for the next cycle.
  - `m_read_valid[rd_owner]` = `s_read_valid & rd_pending`.
  - `m_data_out` = `s_data_in` in every cycle.
  - `s_read_valid` with `rd_pending` = 0 sets `err[0]` and is dropped.
- Read and write together from master i is forwarded as a write only. No read is issued, and `err[1]` is set.
- Lock states are UNLOCKED and LOCKED(owner).
  - UNLOCKED to LOCKED(i): master i transfers with `m_lock[i]` = 1.
  - LOCKED(i) to UNLOCKED: master i transfers with `m_lock[i]` = 0, or the idle counter reaches `LOCK_TIMEOUT`.
  - LOCKED(i) stays LOCKED(i) on a transfer with `m_lock[i]` = 1.
  - The idle counter counts cycles in LOCKED where the owner does not request. It clears on any owner request and on entry to LOCKED.
  - A forced release sets no error flag.
- Flags in `err` clear only by reset.

## Timing
- The command path adds zero cycles: a granted command appears on `s_*` in the same cycle.
- Sustained throughput is one transfer per cycle.
- A read issued in cycle T returns `m_read_valid` and data in cycle T+1. Back-to-back reads from different masters route correctly each cycle.
- Forced lock release: after `LOCK_TIMEOUT` consecutive owner-idle cycles, other masters can be granted in the next cycle.
- While `reset` = 0, all outputs are 0 and `m_waitrequest` is 0. Reset values:
  - `last_grant` = MASTERS-1, so master 0 has first priority.
  - UNLOCKED, idle counter 0.
  - `rd_pending` 0, `err` 0.
- Reset asserted mid-read drops the pending response. The slave shares this reset, so no orphan is flagged.
- `m_waitrequest` for a given master is never asserted for more than `MASTERS-1` consecutive transfers while no lock is held.

## Test plan
- Masters 0 and 1 issue continuous writes from reset, addresses 1 and 2 -> grants alternate 0,1,0,1; `s_address` sequence is 1,2,1,2; each master's waitrequest is high on alternate cycles.
- Master 1 reads address 3 with `s_data_in` = 0xDEADBEEF in the following cycle -> `m_read_valid` = 2'b10 exactly one cycle after the grant, `m_data_out` = 0xDEADBEEF.
- Master 0 does 3 locked writes and then an unlocked one while master 1 requests continuously -> master 1 is stalled for all 4 transfers and granted in the cycle after.
- Master 0 locks and then idles with `LOCK_TIMEOUT` = 16 -> master 1 stays stalled for 16 cycles and is granted on cycle 17.
- `s_read_valid` pulses with no read pending -> `err` = 2'b01 and no `m_read_valid`. Then master 0 drives read and write together -> `s_write` = 1, `s_read` = 0, `err` = 2'b11.
- Reset asserted in the cycle after a read grant -> all outputs are 0 during reset; after release, `err` = 0 and master 0 wins the first contention.
